slc3_mem_responder: RTL and testbench



---
 rtl/slc3_mem_responder_if.sv | 38 +++
 rtl/slc3_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_slc3_mem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/slc3_mem_responder_if.sv
// ---------------------------------------------------------------------------
// slc3_mem_responder_if
//   Memory request bus between the SLC-3 control unit (master) and the
//   memory-side responder (slave).
//
//   mem_mem_ena : request active, held for the wait-state window
//   mem_wr_ena  : 1 = write, 0 = read, qualified by mem_mem_ena
//   mem_addr    : word address (MAR), stable while the request is held
//   mem_wdata   : write data (MDR), stable while the request is held
//   mem_rdata   : read data, held until the next completed read
//   mem_rvalid  : one-cycle pulse when mem_rdata is updated
// ---------------------------------------------------------------------------
interface slc3_mem_responder_if;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output mem_mem_ena,
    output mem_wr_ena,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_mem_ena,
    input  mem_wr_ena,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/slc3_mem_responder.sv
// ---------------------------------------------------------------------------
// slc3_mem_responder
//   Memory-side responder for the SLC-3 datapath. Services the control
//   unit's wait-stated memory requests against an on-chip word RAM plus a
//   single memory-mapped I/O word (switch readback / hex display).
//
//   Ports:
//     clk     : system clock, rising edge
//     reset   : asynchronous, active-low reset
//     bus     : request bus (slave modport of slc3_mem_responder_if)
//     sw_i    : asynchronous switch inputs (2-flop synchronised)
//     hex_o   : hex display register
//     hex_ld  : one-cycle pulse the cycle after hex_o is written
//     err_oob : sticky flag, set by any request to an unmapped address
//
//   Timing: a request starts in cycle C0. Writes commit at the end of C0,
//   exactly once. Reads present data combinationally with a mem_rvalid
//   pulse in cycle C0+READ_LAT-1, so the initiator's MDR load at the end of
//   that cycle captures it; mem_rdata then holds the value.
// ---------------------------------------------------------------------------
module slc3_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          READ_LAT   = 3,
  parameter logic [15:0] MMIO_ADDR  = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  slc3_mem_responder_if.slave   bus,
  input  logic [15:0]           sw_i,
  output logic [15:0]           hex_o,
  output logic                  hex_ld,
  output logic                  err_oob
);

  localparam int         RAM_WORDS = 1 << DEPTH_LOG2;
  localparam logic [2:0] LAST_CNT  = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_HOLD} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_OOB} region_t;

  function automatic region_t decode(input logic [15:0] a);
    if (32'(a) < (32'd1 << DEPTH_LOG2)) return REG_RAM;
    else if (a == MMIO_ADDR)            return REG_MMIO;
    else                                return REG_OOB;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [15:0]           cap_addr_q;
  logic                  cap_wr_q;
  region_t               region_q;
  region_t               req_region;
  logic                  start;
  logic                  rvalid;
  logic                  wr_ram, wr_hex;
  logic [15:0]           rdata_q;
  logic [15:0]           rd_val;
  logic [15:0]           sw_p0, sw_p1;
  logic [15:0]           ram_rd_p0;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [15:0]           ram [RAM_WORDS];

  // A new request begins whenever enable is high and either nothing is in
  // flight or the held address/type no longer matches the captured one.
  assign start = bus.mem_mem_ena &&
                 ((state_q == IDLE) ||
                  (bus.mem_addr != cap_addr_q) ||
                  (bus.mem_wr_ena != cap_wr_q));

  assign req_region = decode(bus.mem_addr);
  assign ram_idx    = bus.mem_addr[DEPTH_LOG2-1:0];
  assign wr_ram     = start && bus.mem_wr_ena && (req_region == REG_RAM);
  assign wr_hex     = start && bus.mem_wr_ena && (req_region == REG_MMIO);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and read-valid decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rvalid  = 1'b0;
    if (start) begin
      if (bus.mem_wr_ena) begin
        state_d = WR_HOLD;
        cnt_d   = '0;
      end else begin
        state_d = RD_WAIT;
        cnt_d   = 3'd1;
      end
    end else if (!bus.mem_mem_ena) begin
      // Covers normal completion as well as an abort from RD_WAIT.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RD_WAIT: begin
          if (cnt_q == LAST_CNT) begin
            rvalid  = 1'b1;
            state_d = RD_DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture, read-data hold, MMIO and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_addr_q <= '0;
      cap_wr_q   <= 1'b0;
      region_q   <= REG_RAM;
      rdata_q    <= '0;
      hex_o      <= '0;
      hex_ld     <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      if (start) begin
        cap_addr_q <= bus.mem_addr;
        cap_wr_q   <= bus.mem_wr_ena;
        region_q   <= req_region;
      end
      if (rvalid) rdata_q <= rd_val;
      if (wr_hex) hex_o <= bus.mem_wdata;
      hex_ld <= wr_hex;
      if (start && (req_region == REG_OOB)) err_oob <= 1'b1;
    end
  end

  // Switch synchroniser, stage 0 -> stage 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw_i;
      sw_p1 <= sw_p0;
    end
  end

  // RAM: read every cycle from the live address; since the address is
  // stable from C0 and READ_LAT >= 2, ram_rd_p0 holds the addressed word
  // by the valid cycle, including after a restart.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= bus.mem_wdata;
    ram_rd_p0 <= ram[ram_idx];
  end

  always_comb begin
    rd_val = '0;
    case (region_q)
      REG_RAM:  rd_val = ram_rd_p0;
      REG_MMIO: rd_val = sw_p1;
      default:  rd_val = '0;
    endcase
  end

  // Fresh data is forwarded in the valid cycle; otherwise hold the last read.
  assign bus.mem_rdata  = rvalid ? rd_val : rdata_q;
  assign bus.mem_rvalid = rvalid;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_slc3_mem_responder
//   Directed bench for slc3_mem_responder (DEPTH_LOG2=10, READ_LAT=3).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_slc3_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw_i = 16'h0000;
  logic [15:0] hex_o;
  logic        hex_ld;
  logic        err_oob;
  int          n_chk = 0;
  int          n_fail = 0;

  slc3_mem_responder_if bus();

  slc3_mem_responder #(
    .DEPTH_LOG2(10),
    .READ_LAT  (3),
    .MMIO_ADDR (16'hFFFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sw_i   (sw_i),
    .hex_o  (hex_o),
    .hex_ld (hex_ld),
    .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle and move to its sample point.
  task automatic drive(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.mem_mem_ena = e;
    bus.mem_wr_ena  = w;
    bus.mem_addr    = a;
    bus.mem_wdata   = d;
    @(negedge clk);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic write_req(input logic [15:0] a, input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, a, d);
      next_cyc();
    end
    drive(1'b0, 1'b0, a, d);
    next_cyc();
  endtask

  task automatic read_req(input string tag, input logic [15:0] a, input logic [15:0] exp);
    drive(1'b1, 1'b0, a, 16'h0);
    chk({tag, "_rv_c1"}, 16'(bus.mem_rvalid), 16'd0);
    next_cyc();
    drive(1'b1, 1'b0, a, 16'h0);
    chk({tag, "_rv_c2"}, 16'(bus.mem_rvalid), 16'd0);
    next_cyc();
    drive(1'b1, 1'b0, a, 16'h0);
    chk({tag, "_rv_c3"}, 16'(bus.mem_rvalid), 16'd1);
    chk({tag, "_data"}, bus.mem_rdata, exp);
    next_cyc();
    drive(1'b0, 1'b0, a, 16'h0);
    chk({tag, "_rv_idle"}, 16'(bus.mem_rvalid), 16'd0);
    chk({tag, "_hold"}, bus.mem_rdata, exp);
    next_cyc();
  endtask

  initial begin
    bus.mem_mem_ena = 1'b0;
    bus.mem_wr_ena  = 1'b0;
    bus.mem_addr    = 16'h0;
    bus.mem_wdata   = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", bus.mem_rdata, 16'h0000);
    chk("rst_rvalid", 16'(bus.mem_rvalid), 16'd0);
    chk("rst_hex", hex_o, 16'h0000);
    chk("rst_hexld", 16'(hex_ld), 16'd0);
    chk("rst_oob", 16'(err_oob), 16'd0);
    next_cyc();
    reset = 1'b1;
    next_cyc();

    // RAM write then read back
    write_req(16'h0000, 16'h0A0A);
    write_req(16'h0006, 16'h6666);
    drive(1'b1, 1'b1, 16'h0005, 16'h1234);
    chk("wr_rv", 16'(bus.mem_rvalid), 16'd0);
    next_cyc();
    drive(1'b1, 1'b1, 16'h0005, 16'h1234);
    chk("wr_hexld", 16'(hex_ld), 16'd0);
    next_cyc();
    drive(1'b1, 1'b1, 16'h0005, 16'h1234);
    next_cyc();
    drive(1'b0, 1'b0, 16'h0005, 16'h0);
    next_cyc();
    read_req("rd5", 16'h0005, 16'h1234);
    chk("rd5_oob", 16'(err_oob), 16'd0);

    // Hex display write: load once, single hex_ld pulse
    drive(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    chk("hex_c0_val", hex_o, 16'h0000);
    chk("hex_c0_ld", 16'(hex_ld), 16'd0);
    next_cyc();
    drive(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    chk("hex_c1_val", hex_o, 16'hBEEF);
    chk("hex_c1_ld", 16'(hex_ld), 16'd1);
    next_cyc();
    drive(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    chk("hex_c2_ld", 16'(hex_ld), 16'd0);
    next_cyc();
    drive(1'b0, 1'b0, 16'hFFFF, 16'h0);
    chk("hex_idle_ld", 16'(hex_ld), 16'd0);
    chk("hex_idle_val", hex_o, 16'hBEEF);
    next_cyc();

    // Switch readback through the synchroniser
    sw_i = 16'h00A5;
    repeat (4) next_cyc();
    read_req("sw", 16'hFFFF, 16'h00A5);

    // Unmapped read and write
    drive(1'b1, 1'b0, 16'h8000, 16'h0);
    next_cyc();
    drive(1'b1, 1'b0, 16'h8000, 16'h0);
    chk("oob_set", 16'(err_oob), 16'd1);
    next_cyc();
    drive(1'b1, 1'b0, 16'h8000, 16'h0);
    chk("oob_rv", 16'(bus.mem_rvalid), 16'd1);
    chk("oob_data", bus.mem_rdata, 16'h0000);
    next_cyc();
    drive(1'b0, 1'b0, 16'h8000, 16'h0);
    next_cyc();
    write_req(16'h8000, 16'h7777);
    chk("oob_sticky", 16'(err_oob), 16'd1);
    read_req("rd0", 16'h0000, 16'h0A0A);

    // Abort after one cycle: no valid, data held
    drive(1'b1, 1'b0, 16'h0005, 16'h0);
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0005, 16'h0);
      chk("abort_rv", 16'(bus.mem_rvalid), 16'd0);
      chk("abort_data", bus.mem_rdata, 16'h0A0A);
      next_cyc();
    end

    // Restart: address change in cycle 2 becomes the new C0
    drive(1'b1, 1'b0, 16'h0005, 16'h0);
    next_cyc();
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    chk("rs_c1_rv", 16'(bus.mem_rvalid), 16'd0);
    next_cyc();
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    chk("rs_c2_rv", 16'(bus.mem_rvalid), 16'd0);
    next_cyc();
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    chk("rs_c3_rv", 16'(bus.mem_rvalid), 16'd1);
    chk("rs_data", bus.mem_rdata, 16'h6666);
    next_cyc();
    drive(1'b0, 1'b0, 16'h0006, 16'h0);
    next_cyc();

    // Reset mid-read
    drive(1'b1, 1'b0, 16'h0005, 16'h0);
    next_cyc();
    drive(1'b1, 1'b0, 16'h0005, 16'h0);
    reset = 1'b0;
    bus.mem_mem_ena = 1'b0;
    #1;
    chk("mrst_rdata", bus.mem_rdata, 16'h0000);
    chk("mrst_rvalid", 16'(bus.mem_rvalid), 16'd0);
    chk("mrst_hex", hex_o, 16'h0000);
    chk("mrst_hexld", 16'(hex_ld), 16'd0);
    chk("mrst_oob", 16'(err_oob), 16'd0);
    next_cyc();
    reset = 1'b1;
    next_cyc();
    read_req("post_rst", 16'h0005, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
